fifo_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the write port of the UART TX asynchronous FIFO among NREQ byte producers in the write clock domain. It grants one requester at a time, holds the grant for a packet or at most MAXBURST bytes, and drives the FIFO's write-enable and write-data from the owner. All writes are gated by the FIFO full flag. It also counts cycles lost to back-pressure.

---
 rtl/fifo_arb_pkg.sv | 18 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 35 +++
 rtl/fifo_wr_arbiter.sv | 114 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared constants for the UART TX FIFO write-side arbiter and the FIFO top.
package fifo_arb_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_OWN  = 1'b1;

  localparam int ARB_NREQ     = 4;
  localparam int ARB_DWIDTH   = 8;
  localparam int ARB_MAXBURST = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating priority encoder: first requester above last_owner, wrapping around.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = ARB_NREQ
) (
  input  logic [NREQ-1:0]        req,
  input  logic [clog2(NREQ)-1:0] last_owner,
  output logic [clog2(NREQ)-1:0] winner,
  output logic                   any_req
);
  localparam int OW = clog2(NREQ);

  logic          found;
  logic [OW-1:0] idx;
  int            s;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    s      = 0;
    for (int i = 1; i <= NREQ; i++) begin
      s   = (int'(last_owner) + i) % NREQ;
      idx = OW'(s);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin owner of the TX FIFO write port; grant held for one packet or MAXBURST bytes.
// Writes are gated by wfull; blocked owner cycles are counted in a saturating stall counter.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ     = ARB_NREQ,
  parameter int DWIDTH   = ARB_DWIDTH,
  parameter int MAXBURST = ARB_MAXBURST,
  parameter int SCNT_W   = 16
) (
  input  logic                     wrclk,
  input  logic                     wrst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          gnt,
  input  logic                     wfull,
  output logic                     winc,
  output logic [DWIDTH-1:0]        wdata,
  output logic                     busy,
  output logic [clog2(NREQ)-1:0]   owner,
  input  logic                     stall_clr,
  output logic [SCNT_W-1:0]        stall_cnt
);
  localparam int OW = clog2(NREQ);
  localparam int BW = clog2(MAXBURST + 1);
  localparam logic [BW-1:0] BURST_END = BW'(MAXBURST - 1);

  logic              state_q, state_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     last_owner_q, last_owner_d;
  logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
  logic [SCNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [OW-1:0] winner;
  logic          any_req;
  logic          cur_req, cur_last, xfer, stall;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .winner     (winner),
    .any_req    (any_req)
  );

  assign cur_req  = req[owner_q];
  assign cur_last = req_last[owner_q];
  assign xfer     = (state_q == ST_OWN) && cur_req && !wfull;

  always_ff @(posedge wrclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= OW'(NREQ - 1);
      burst_cnt_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    stall        = 1'b0;
    if (state_q == ST_IDLE) begin
      if (any_req) begin
        owner_d     = winner;
        burst_cnt_d = '0;
        state_d     = ST_OWN;
      end
    end else if (!cur_req) begin
      // Withdrawn packet is abandoned; rotation still advances past this owner.
      last_owner_d = owner_q;
      state_d      = ST_IDLE;
    end else if (wfull) begin
      stall = 1'b1;
    end else begin
      burst_cnt_d = burst_cnt_q + 1'b1;
      if (cur_last || burst_cnt_q == BURST_END) begin
        last_owner_d = owner_q;
        state_d      = ST_IDLE;
      end
    end

    if (stall_clr)
      stall_cnt_d = '0;
    else if (stall && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + 1'b1;
    else
      stall_cnt_d = stall_cnt_q;
  end

  always_comb begin
    winc  = xfer;
    gnt   = '0;
    wdata = '0;
    if (xfer)
      gnt[owner_q] = 1'b1;
    if (state_q == ST_OWN)
      wdata = req_data[owner_q*DWIDTH +: DWIDTH];
  end

  assign busy      = (state_q == ST_OWN);
  assign owner     = owner_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=4, MAXBURST=4, narrow stall counter).
module tb_fifo_wr_arbiter;

  logic        wrclk;
  logic        wrst_n;
  logic [3:0]  req;
  logic [7:0]  d [4];
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  gnt;
  logic        wfull;
  logic        winc;
  logic [7:0]  wdata;
  logic        busy;
  logic [1:0]  owner;
  logic        stall_clr;
  logic [3:0]  stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  assign req_data = {d[3], d[2], d[1], d[0]};

  fifo_wr_arbiter #(
    .NREQ(4), .DWIDTH(8), .MAXBURST(4), .SCNT_W(4)
  ) dut (
    .wrclk     (wrclk),
    .wrst_n    (wrst_n),
    .req       (req),
    .req_data  (req_data),
    .req_last  (req_last),
    .gnt       (gnt),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .busy      (busy),
    .owner     (owner),
    .stall_clr (stall_clr),
    .stall_cnt (stall_cnt)
  );

  initial wrclk = 1'b0;
  always #5 wrclk = ~wrclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    int g;
    int e;
    wrst_n    = 1'b0;
    req       = '0;
    req_last  = '0;
    wfull     = 1'b0;
    stall_clr = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = '0;

    #2;
    chk("rst_busy", busy, 0);
    chk("rst_winc", winc, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_owner", owner, 0);
    chk("rst_stall", stall_cnt, 0);
    @(negedge wrclk); wrst_n = 1'b1;

    // single requester, 3-byte packet
    @(negedge wrclk); req = 4'b0001; d[0] = 8'h11; #1;
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_winc", winc, 0);
    @(negedge wrclk); #1;
    chk("t1_b0_busy", busy, 1);
    chk("t1_b0_owner", owner, 0);
    chk("t1_b0_winc", winc, 1);
    chk("t1_b0_gnt", gnt, 4'b0001);
    chk("t1_b0_wdata", wdata, 8'h11);
    @(negedge wrclk); d[0] = 8'h22; #1;
    chk("t1_b1_winc", winc, 1);
    chk("t1_b1_wdata", wdata, 8'h22);
    @(negedge wrclk); d[0] = 8'h33; req_last = 4'b0001; #1;
    chk("t1_b2_winc", winc, 1);
    chk("t1_b2_wdata", wdata, 8'h33);
    @(negedge wrclk); req = '0; req_last = '0; #1;
    chk("t1_end_busy", busy, 0);
    chk("t1_end_winc", winc, 0);
    wrst_n = 1'b0; #1; wrst_n = 1'b1;

    // all requesting, bursts capped at 4 bytes
    for (int i = 0; i < 4; i++) d[i] = 8'hA0 + 8'(i);
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      @(negedge wrclk); req = 4'hF; #1;
      chk("t2_gap_busy", busy, 0);
      chk("t2_gap_winc", winc, 0);
      for (int b = 0; b < 4; b++) begin
        @(negedge wrclk); #1;
        chk("t2_owner", owner, g);
        chk("t2_gnt", gnt, 32'(1 << g));
        chk("t2_winc", winc, 1);
        chk("t2_wdata", wdata, 8'hA0 + 8'(g));
      end
    end

    // owner 2 stalled by wfull while req1 waits
    @(negedge wrclk); req = 4'b0100; d[2] = 8'h51; #1;
    chk("t3_idle_busy", busy, 0);
    @(negedge wrclk); #1;
    chk("t3_owner", owner, 2);
    chk("t3_b0_gnt", gnt, 4'b0100);
    chk("t3_b0_wdata", wdata, 8'h51);
    for (int k = 0; k < 5; k++) begin
      @(negedge wrclk); req = 4'b0110; d[2] = 8'h52; wfull = 1'b1; #1;
      chk("t3_st_winc", winc, 0);
      chk("t3_st_gnt", gnt, 0);
      chk("t3_st_owner", owner, 2);
      chk("t3_st_cnt", stall_cnt, k);
    end
    @(negedge wrclk); wfull = 1'b0; req_last = 4'b0100; #1;
    chk("t3_rel_winc", winc, 1);
    chk("t3_rel_gnt", gnt, 4'b0100);
    chk("t3_rel_wdata", wdata, 8'h52);
    chk("t3_rel_cnt", stall_cnt, 5);

    // owner 1 withdraws after 2 bytes, requester 2 takes over
    @(negedge wrclk); req = 4'b0010; req_last = '0; d[1] = 8'h61; #1;
    chk("t4_idle_busy", busy, 0);
    @(negedge wrclk); #1;
    chk("t4_owner", owner, 1);
    chk("t4_b0_gnt", gnt, 4'b0010);
    chk("t4_b0_wdata", wdata, 8'h61);
    @(negedge wrclk); d[1] = 8'h62; #1;
    chk("t4_b1_gnt", gnt, 4'b0010);
    chk("t4_b1_wdata", wdata, 8'h62);
    @(negedge wrclk); req = 4'b0100; d[2] = 8'h71; req_last = 4'b0100; #1;
    chk("t4_drop_winc", winc, 0);
    chk("t4_drop_gnt", gnt, 0);
    chk("t4_drop_busy", busy, 1);
    @(negedge wrclk); #1;
    chk("t4_gap_busy", busy, 0);
    @(negedge wrclk); #1;
    chk("t4_next_owner", owner, 2);
    chk("t4_next_gnt", gnt, 4'b0100);
    chk("t4_next_wdata", wdata, 8'h71);

    // stall counter saturation and clear
    @(negedge wrclk); req = 4'b0001; req_last = '0; d[0] = 8'h91; #1;
    chk("t5_idle_busy", busy, 0);
    for (int k = 0; k < 14; k++) begin
      @(negedge wrclk); wfull = 1'b1; #1;
      e = (5 + k > 15) ? 15 : 5 + k;
      chk("t5_st_winc", winc, 0);
      chk("t5_st_cnt", stall_cnt, e);
    end
    @(negedge wrclk); stall_clr = 1'b1; #1;
    chk("t5_clr_cnt", stall_cnt, 15);
    @(negedge wrclk); stall_clr = 1'b0; #1;
    chk("t5_after_clr", stall_cnt, 0);
    @(negedge wrclk); #1;
    chk("t5_recount", stall_cnt, 1);
    @(negedge wrclk); wfull = 1'b0; req_last = 4'b0001; #1;
    chk("t5_rel_winc", winc, 1);
    chk("t5_rel_wdata", wdata, 8'h91);

    // async reset mid-burst of requester 3
    @(negedge wrclk); req = 4'b1000; req_last = '0; d[3] = 8'h81; #1;
    chk("t6_idle_busy", busy, 0);
    @(negedge wrclk); #1;
    chk("t6_owner", owner, 3);
    chk("t6_b0_gnt", gnt, 4'b1000);
    chk("t6_b0_wdata", wdata, 8'h81);
    @(negedge wrclk); d[3] = 8'h82; #1;
    chk("t6_b1_wdata", wdata, 8'h82);
    @(negedge wrclk); wrst_n = 1'b0; #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_winc", winc, 0);
    chk("t6_rst_gnt", gnt, 0);
    chk("t6_rst_wdata", wdata, 0);
    chk("t6_rst_owner", owner, 0);
    chk("t6_rst_stall", stall_cnt, 0);
    @(negedge wrclk); wrst_n = 1'b1; req = 4'b1001; d[0] = 8'hA1; #1;
    chk("t6_rel_busy", busy, 0);
    @(negedge wrclk); #1;
    chk("t6_first_owner", owner, 0);
    chk("t6_first_gnt", gnt, 4'b0001);
    chk("t6_first_wdata", wdata, 8'hA1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
